seq_pattern_gen: RTL and testbench

Serial pattern generator that drives the one-bit `x` input of the team's sequence detectors. It captures a parallel pattern, then shifts it out MSB-first, one bit per clock, with a ready/start handshake and a completion pulse. It replaces hand-written stimulus loops and serves as the on-chip source when a detector is exercised in a loopback.

---
 rtl/seq_gen_pkg.sv | 9 +
 rtl/seq_gen_bitcnt.sv | 18 +
 rtl/seq_pattern_gen.sv | 66 ++++++
 tb/tb_seq_pattern_gen.sv | 126 ++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared state type, default sizes and length normalisation for seq_pattern_gen
package seq_gen_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_LEN_W = 5;
  function automatic int norm_len(input int len, input int width);
    return (len == 0 || len > width) ? width : len;
  endfunction
endpackage

// File: rtl/seq_gen_bitcnt.sv
// seq_gen_bitcnt: loadable down-counter (clk, reset, load/val, dec) with zero flag (cnt, zero)
module seq_gen_bitcnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] val,
  output logic [W-1:0] cnt,
  output logic         zero
);
  assign zero = cnt == '0;
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (load) cnt <= val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: MSB-first serial pattern source; in clk/reset/load/pattern/length/start(/repeat_pass with SEQ_GEN_REPEAT_EN), out ready/x/valid/done
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] length,
  input  logic             start,
`ifdef SEQ_GEN_REPEAT_EN
  input  logic             repeat_pass,
`endif
  output logic             ready,
  output logic             x,
  output logic             valid,
  output logic             done
);
  state_t           state;
  logic [WIDTH-1:0] pat, sh;
  logic [LEN_W-1:0] slen, new_len, len_now, cnt;
  logic             zero, go, rpt, cnt_load;
`ifdef SEQ_GEN_REPEAT_EN
  assign rpt = repeat_pass;
`else
  assign rpt = 1'b0;
`endif
  assign go       = state == IDLE && start;
  assign new_len  = LEN_W'(norm_len(int'(length), WIDTH));
  assign len_now  = (go && load) ? new_len : slen;
  assign cnt_load = go || (state == SHIFT && zero && rpt);
  assign sh       = pat >> cnt;
  seq_gen_bitcnt #(.W(LEN_W)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .load (cnt_load),
    .dec  (state == SHIFT),
    .val  (len_now - 1'b1),
    .cnt  (cnt),
    .zero (zero)
  );
  // outputs lag the counter by one edge, so ready only rises the cycle after done
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      pat   <= '0;
      slen  <= LEN_W'(WIDTH);
      ready <= 1'b1;
      x     <= 1'b0;
      valid <= 1'b0;
      done  <= 1'b0;
    end else begin
      if (state == IDLE && load) begin
        pat  <= pattern;
        slen <= new_len;
      end
      state <= (state == IDLE) ? (start ? SHIFT : IDLE) : ((zero && !rpt) ? IDLE : SHIFT);
      ready <= state == IDLE && !start;
      valid <= state == SHIFT;
      x     <= state == SHIFT && sh[0];
      done  <= state == SHIFT && zero;
    end
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: scoreboard bench for seq_pattern_gen
module tb_seq_pattern_gen;
  logic        clk = 0, reset = 1, load = 0, start = 0, rpt = 0;
  logic [15:0] pattern = '0;
  logic [4:0]  length = '0;
  logic        ready, x, valid, done;
  logic [1:0]  exp_q[$];
  logic [15:0] m_pat = '0;
  int          m_len = 16;
  int          n_chk = 0, n_fail = 0;
  logic        mon_en = 0, prev_done = 0, rpt_seen = 0;

  always #5 clk = ~clk;

  seq_pattern_gen dut (
    .clk(clk), .reset(reset), .load(load), .pattern(pattern), .length(length), .start(start),
`ifdef SEQ_GEN_REPEAT_EN
    .repeat_pass(rpt),
`endif
    .ready(ready), .x(x), .valid(valid), .done(done)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h @%0t", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pass();
    for (int k = m_len - 1; k >= 0; k--) exp_q.push_back({m_pat[k], k == 0});
  endtask

  task automatic kick(input logic ld, input logic st, input logic [15:0] p, input logic [4:0] len);
    load = ld; start = st; pattern = p; length = len;
    if (ld) begin
      m_pat = p;
      m_len = (len == 0 || len > 16) ? 16 : int'(len);
    end
    if (st) push_pass();
    tick();
    load = 0; start = 0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 60; i++) begin
      if (ready && exp_q.size() == 0) break;
      tick();
    end
    check("idle_timeout", 16'(i < 60), 16'd1);
  endtask

  always @(negedge clk) if (mon_en) begin
    if (prev_done && !rpt_seen) check("ready_after_done", 16'(ready), 16'd1);
    if (valid) begin
      check("ready_low_in_pass", 16'(ready), 16'd0);
      if (exp_q.size() == 0) check("extra_valid", 16'(valid), 16'd0);
      else check("bit_done", 16'({x, done}), 16'(exp_q.pop_front()));
    end else check("idle_x_done", 16'({x, done}), 16'd0);
    prev_done = done;
  end

  initial begin
    tick(); tick();
    reset = 0;
    check("rst_ready", 16'(ready), 16'd1);
    check("rst_x", 16'(x), 16'd0);
    check("rst_valid", 16'(valid), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    mon_en = 1;
    kick(1, 0, 16'b1101011011010110, 5'd16);
    kick(0, 1, 16'h0000, 5'd0);
    wait_idle();
    kick(1, 1, 16'h000B, 5'd4);
    wait_idle();
    kick(1, 1, 16'hA5C3, 5'd0);
    wait_idle();
    kick(1, 1, 16'h3C96, 5'd20);
    wait_idle();
    kick(1, 1, 16'h0001, 5'd1);
    wait_idle();
    kick(1, 1, 16'h9A6C, 5'd16);
    repeat (3) tick();
    load = 1; start = 1; pattern = 16'hFFFF; length = 5'd16;
    tick();
    load = 0; start = 0;
    wait_idle();
    kick(0, 1, 16'h0000, 5'd0);
    check("mid_pass_ready", 16'(ready), 16'd0);
    repeat (6) tick();
    reset = 1;
    tick();
    reset = 0;
    exp_q.delete();
    m_pat = '0; m_len = 16;
    check("rst_mid_ready", 16'(ready), 16'd1);
    check("rst_mid_valid", 16'(valid), 16'd0);
    check("rst_mid_x", 16'(x), 16'd0);
    check("rst_mid_done", 16'(done), 16'd0);
    kick(0, 1, 16'h0000, 5'd0);
    wait_idle();
`ifdef SEQ_GEN_REPEAT_EN
    rpt = 1; rpt_seen = 1;
    kick(1, 1, 16'h0005, 5'd3);
    push_pass(); push_pass();
    repeat (7) tick();
    rpt = 0;
    wait_idle();
    tick();
    rpt_seen = 0;
`endif
    tick();
    check("queue_empty", 16'(exp_q.size()), 16'd0);
    check("final_ready", 16'(ready), 16'd1);
    mon_en = 0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
